// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and defaults for the data-memory arbiter
package dmem_arb_pkg;

    localparam int DMEM_MEM_BYTES = 1024;
    localparam int DMEM_ADDR_W    = 32;
    localparam int DMEM_DATA_W    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_t;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        owner_t                 owner;
    } dmem_req_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - requester selection; DMEM_ARB_RR_EN selects round-robin over fixed priority
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  owner_t     last,
    output logic [1:0] gnt
);

`ifdef DMEM_ARB_RR_EN
    // On a tie the requester that did not win last time goes next.
    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
            gnt = (last == OWN_M0) ? 2'b10 : 2'b01;
        end else begin
            gnt = {req1, req0};
        end
    end
`else
    logic unused_last;
    assign unused_last = last;
    assign gnt         = {req1 & ~req0, req0};
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter/sequencer for the 256x32 data memory (DMEM_ARB_RR_EN: round-robin)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_BYTES = DMEM_MEM_BYTES,
    parameter int ADDR_W    = DMEM_ADDR_W,
    parameter int DATA_W    = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state;
    state_t            state_nxt;
    dmem_req_t         req_r;
    logic [DATA_W-1:0] rdata_r;
    logic              err_r;
    logic [1:0]        pick;
    logic [1:0]        gnt;
    logic              can_grant;
    logic              issuing;
    logic              legal;

    // The owner of the last captured request doubles as the round-robin pointer.
    dmem_arb_pick u_pick (
        .req0 (m0_req),
        .req1 (m1_req),
        .last (req_r.owner),
        .gnt  (pick)
    );

    assign can_grant = rst_n && (state != ISSUE);
    assign gnt       = can_grant ? pick : 2'b00;
    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];

    assign issuing = (state == ISSUE);
    assign legal   = (req_r.addr[1:0] == 2'b00) && (req_r.addr < ADDR_W'(MEM_BYTES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (|gnt) ? ISSUE : IDLE;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = (|gnt) ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_r   <= '{we: 1'b0, addr: '0, wdata: '0, owner: OWN_M1};
            rdata_r <= '0;
            err_r   <= 1'b0;
        end else begin
            if (|gnt) begin
                req_r <= '{we:    gnt[1] ? m1_we    : m0_we,
                           addr:  gnt[1] ? m1_addr  : m0_addr,
                           wdata: gnt[1] ? m1_wdata : m0_wdata,
                           owner: gnt[1] ? OWN_M1   : OWN_M0};
            end
            if (issuing) begin
                rdata_r <= (legal && !req_r.we) ? mem_rdata : '0;
                err_r   <= !legal;
            end
        end
    end

    // Illegal requests still present their address but never enable the memory.
    assign mem_read  = issuing && legal && !req_r.we;
    assign mem_write = issuing && legal && req_r.we;
    assign mem_addr  = issuing ? req_r.addr  : '0;
    assign mem_wdata = issuing ? req_r.wdata : '0;

    assign m0_rvalid = (state == RESP) && (req_r.owner == OWN_M0);
    assign m1_rvalid = (state == RESP) && (req_r.owner == OWN_M1);
    assign m0_rdata  = m0_rvalid ? rdata_r : '0;
    assign m1_rdata  = m1_rvalid ? rdata_r : '0;
    assign m0_err    = m0_rvalid && err_r;
    assign m1_err    = m1_rvalid && err_r;

endmodule
